// File: rtl/axi_master_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// Module      : axi_master_arbiter_pkg
// Description : Shared master IDs, FSM state encoding and AXI3 bundle types
//               for the cache-side AXI master arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
package axi_master_arbiter_pkg;

    localparam int ID_ICACHE   = 0;
    localparam int ID_DCACHE   = 1;
    localparam int ID_UNCACHED = 2;
    localparam int ID_IDX_W    = 2;

    typedef enum logic [2:0] {
        AR_IDLE = 3'd0,
        AR_BUSY = 3'd1,
        W_IDLE  = 3'd2,
        W_ADDR  = 3'd3,
        W_DATA  = 3'd4,
        W_RESP  = 3'd5
    } arb_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
    } axi_ax_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        axi_ax_t ar;
        axi_ax_t aw;
        axi_w_t  w;
        logic    rready;
        logic    bready;
    } axi_req_t;

    typedef struct packed {
        logic   arready;
        logic   awready;
        logic   wready;
        axi_r_t r;
        axi_b_t b;
    } axi_resp_t;

    function automatic logic [ID_IDX_W-1:0] next_idx(input logic [ID_IDX_W-1:0] idx,
                                                     input int n);
        return ID_IDX_W'((int'(idx) + 1) % n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_master_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module      : axi_master_arbiter_if
// Description : Bundle of per-master and merged AXI signals; the master modport
//               is the arbiter view, the slave modport the surrounding system.
// Revision    : 1.0 - initial release
// =============================================================================
interface axi_master_arbiter_if
    import axi_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int BUS_WIDTH   = 4
);
    axi_req_t               s_req  [NUM_MASTERS];
    axi_resp_t              s_resp [NUM_MASTERS];
    axi_req_t               m_req;
    logic [BUS_WIDTH-1:0]   m_arid;
    logic [BUS_WIDTH-1:0]   m_awid;
    logic [BUS_WIDTH-1:0]   m_wid;
    axi_resp_t              m_resp;
    logic [BUS_WIDTH-1:0]   m_rid;
    logic [BUS_WIDTH-1:0]   m_bid;

    modport master (
        input  s_req, m_resp, m_rid, m_bid,
        output s_resp, m_req, m_arid, m_awid, m_wid
    );

    modport slave (
        output s_req, m_resp, m_rid, m_bid,
        input  s_resp, m_req, m_arid, m_awid, m_wid
    );
endinterface
`default_nettype wire

// File: rtl/axi_master_arbiter_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : axi_master_arbiter_rr_arbiter
// Description : Combinational request arbiter: round-robin from ptr, or fixed
//               dcache > uncached > icache when AXI_ARB_FIXED_PRIO_EN is set.
// Revision    : 1.0 - initial release
// =============================================================================
module axi_master_arbiter_rr_arbiter
    import axi_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3
)
(
    input  logic [NUM_MASTERS-1:0] req,
`ifndef AXI_ARB_FIXED_PRIO_EN
    input  logic [ID_IDX_W-1:0]    ptr,
`endif
    output logic [NUM_MASTERS-1:0] grant,
    output logic [ID_IDX_W-1:0]    idx
);

`ifdef AXI_ARB_FIXED_PRIO_EN
    always_comb begin
        idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_IDX_W'(i);
        end
        if (req[ID_UNCACHED]) idx = ID_IDX_W'(ID_UNCACHED);
        if (req[ID_DCACHE])   idx = ID_IDX_W'(ID_DCACHE);
    end
`else
    // Scanning offsets downward lets the candidate closest to ptr win last.
    always_comb begin
        logic [ID_IDX_W-1:0] w_cand;
        idx    = '0;
        w_cand = '0;
        for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
            w_cand = ID_IDX_W'((int'(ptr) + off) % NUM_MASTERS);
            if (req[w_cand]) idx = w_cand;
        end
    end
`endif

    assign grant = (|req) ? (NUM_MASTERS'(1) << idx) : '0;

endmodule
`default_nettype wire

// File: rtl/axi_master_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : axi_master_arbiter
// Description : Merges icache/dcache/uncached AXI3 masters onto one port.
//               Build option: AXI_ARB_FIXED_PRIO_EN selects fixed priority.
// Revision    : 1.0 - initial release
// =============================================================================
module axi_master_arbiter
    import axi_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int BUS_WIDTH   = 4
)
(
    input  logic                 aclk,
    input  logic                 reset_n,
    axi_master_arbiter_if.master bus
);

    arb_state_e             r_ar_state, w_ar_state_nxt;
    arb_state_e             r_w_state,  w_w_state_nxt;
    logic [ID_IDX_W-1:0]    r_g_r, w_g_r_nxt;
    logic [ID_IDX_W-1:0]    r_g_w, w_g_w_nxt;
`ifndef AXI_ARB_FIXED_PRIO_EN
    logic [ID_IDX_W-1:0]    r_rr_ar, w_rr_ar_nxt;
    logic [ID_IDX_W-1:0]    r_rr_aw, w_rr_aw_nxt;
`endif

    logic [NUM_MASTERS-1:0] w_ar_req, w_aw_req, w_ar_grant, w_aw_grant;
    logic [ID_IDX_W-1:0]    w_ar_idx, w_aw_idx, w_rk;
    axi_req_t               w_m_req;
    axi_resp_t              w_s_resp [NUM_MASTERS];
    logic [BUS_WIDTH-1:0]   w_arid, w_awid, w_wid;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
        assign w_ar_req[i]   = bus.s_req[i].ar.valid;
        assign w_aw_req[i]   = bus.s_req[i].aw.valid;
        assign bus.s_resp[i] = w_s_resp[i];
    end

    axi_master_arbiter_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_ar_arb (
        .req   (w_ar_req),
`ifndef AXI_ARB_FIXED_PRIO_EN
        .ptr   (r_rr_ar),
`endif
        .grant (w_ar_grant),
        .idx   (w_ar_idx)
    );

    axi_master_arbiter_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_aw_arb (
        .req   (w_aw_req),
`ifndef AXI_ARB_FIXED_PRIO_EN
        .ptr   (r_rr_aw),
`endif
        .grant (w_aw_grant),
        .idx   (w_aw_idx)
    );

    assign w_rk        = bus.m_rid[ID_IDX_W-1:0];
    assign bus.m_req   = w_m_req;
    assign bus.m_arid  = w_arid;
    assign bus.m_awid  = w_awid;
    assign bus.m_wid   = w_wid;

    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ar_state <= AR_IDLE;
            r_w_state  <= W_IDLE;
            r_g_r      <= '0;
            r_g_w      <= '0;
`ifndef AXI_ARB_FIXED_PRIO_EN
            r_rr_ar    <= '0;
            r_rr_aw    <= '0;
`endif
        end else begin
            r_ar_state <= w_ar_state_nxt;
            r_w_state  <= w_w_state_nxt;
            r_g_r      <= w_g_r_nxt;
            r_g_w      <= w_g_w_nxt;
`ifndef AXI_ARB_FIXED_PRIO_EN
            r_rr_ar    <= w_rr_ar_nxt;
            r_rr_aw    <= w_rr_aw_nxt;
`endif
        end
    end

    always_comb begin
        w_ar_state_nxt = r_ar_state;
        w_w_state_nxt  = r_w_state;
        w_g_r_nxt      = r_g_r;
        w_g_w_nxt      = r_g_w;
`ifndef AXI_ARB_FIXED_PRIO_EN
        w_rr_ar_nxt    = r_rr_ar;
        w_rr_aw_nxt    = r_rr_aw;
`endif
        w_m_req = '0;
        w_arid  = '0;
        w_awid  = '0;
        w_wid   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) w_s_resp[i] = '0;

        // R beats follow their ID alone; IDs with no owner are drained.
        if (int'(w_rk) < NUM_MASTERS) begin
            w_s_resp[w_rk].r = bus.m_resp.r;
            w_m_req.rready   = bus.s_req[w_rk].rready;
        end else begin
            w_m_req.rready   = 1'b1;
        end

        case (r_ar_state)
            AR_IDLE: begin
                if (|w_ar_grant) begin
                    w_g_r_nxt      = w_ar_idx;
                    w_ar_state_nxt = AR_BUSY;
                end
            end
            AR_BUSY: begin
                w_m_req.ar              = bus.s_req[r_g_r].ar;
                w_arid                  = BUS_WIDTH'(r_g_r);
                w_s_resp[r_g_r].arready = bus.m_resp.arready;
                if (w_m_req.ar.valid && bus.m_resp.arready) begin
                    w_ar_state_nxt = AR_IDLE;
`ifndef AXI_ARB_FIXED_PRIO_EN
                    w_rr_ar_nxt    = next_idx(r_g_r, NUM_MASTERS);
`endif
                end
            end
            default: w_ar_state_nxt = AR_IDLE;
        endcase

        case (r_w_state)
            W_IDLE: begin
                if (|w_aw_grant) begin
                    w_g_w_nxt     = w_aw_idx;
                    w_w_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                w_m_req.aw              = bus.s_req[r_g_w].aw;
                w_awid                  = BUS_WIDTH'(r_g_w);
                w_s_resp[r_g_w].awready = bus.m_resp.awready;
                if (w_m_req.aw.valid && bus.m_resp.awready) w_w_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_m_req.w              = bus.s_req[r_g_w].w;
                w_wid                  = BUS_WIDTH'(r_g_w);
                w_s_resp[r_g_w].wready = bus.m_resp.wready;
                if (w_m_req.w.valid && bus.m_resp.wready && w_m_req.w.last)
                    w_w_state_nxt = W_RESP;
            end
            W_RESP: begin
                w_m_req.bready    = bus.s_req[r_g_w].bready;
                w_s_resp[r_g_w].b = bus.m_resp.b;
                if (bus.m_resp.b.valid && w_m_req.bready) begin
                    w_w_state_nxt = W_IDLE;
`ifndef AXI_ARB_FIXED_PRIO_EN
                    w_rr_aw_nxt   = next_idx(r_g_w, NUM_MASTERS);
`endif
                end
            end
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    // A B response is always handed to the write owner; a foreign BID is flagged.
    a_bid_matches_owner: assert property (@(posedge aclk) disable iff (!reset_n)
        (r_w_state == W_RESP && bus.m_resp.b.valid) |-> (bus.m_bid == BUS_WIDTH'(r_g_w)));

endmodule
`default_nettype wire

// File: tb/tb_axi_master_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_axi_master_arbiter
// Description : Directed bench for axi_master_arbiter: R routing table plus
//               AR/AW/W/B and reset sequences (AXI_ARB_FIXED_PRIO_EN aware).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_axi_master_arbiter;
    import axi_master_arbiter_pkg::*;

    logic aclk    = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    axi_master_arbiter_if bus ();

    axi_master_arbiter dut (
        .aclk    (aclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  rid;
        logic [2:0]  rready;
        logic [31:0] data;
        logic [2:0]  exp_valid;
        logic        exp_rready;
    } rvec_t;

    rvec_t rv [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) bus.s_req[i] = '0;
        bus.m_resp = '0;
        bus.m_rid  = '0;
        bus.m_bid  = '0;
    endtask

    function automatic axi_ax_t mk_ax(input logic [31:0] a, input logic [3:0] l);
        return '{valid:1'b1, addr:a, len:l, size:3'd2, burst:2'd1,
                 lock:2'd0, cache:4'd3, prot:3'd2};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rv[0] = '{4'd1, 3'b010, 32'hA1, 3'b010, 1'b1};
        rv[1] = '{4'd2, 3'b010, 32'hA2, 3'b100, 1'b0};
        rv[2] = '{4'd1, 3'b000, 32'hA3, 3'b010, 1'b0};
        rv[3] = '{4'd3, 3'b000, 32'hA4, 3'b000, 1'b1};
        rv[4] = '{4'd0, 3'b110, 32'hA5, 3'b001, 1'b0};
        rv[5] = '{4'd2, 3'b111, 32'hA6, 3'b100, 1'b1};
        rv[6] = '{4'd3, 3'b111, 32'hA7, 3'b000, 1'b1};
        rv[7] = '{4'd0, 3'b001, 32'hA8, 3'b001, 1'b1};

        // Reset: outputs idle even with every request and slave ready active
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.s_req[i].ar = mk_ax(32'h1000 * (i + 1), 4'd1);
            bus.s_req[i].aw = mk_ax(32'h8000 * (i + 1), 4'd1);
        end
        bus.m_resp.arready = 1'b1;
        bus.m_resp.awready = 1'b1;
        bus.m_resp.wready  = 1'b1;
        tick();
        tick();
        chk("rst_arvalid", bus.m_req.ar.valid, 0);
        chk("rst_awvalid", bus.m_req.aw.valid, 0);
        chk("rst_araddr",  bus.m_req.ar.addr, 0);
        chk("rst_awaddr",  bus.m_req.aw.addr, 0);
        chk("rst_bready",  bus.m_req.bready, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_s_arready", bus.s_resp[i].arready, 0);
            chk("rst_s_awready", bus.s_resp[i].awready, 0);
            chk("rst_s_wready",  bus.s_resp[i].wready, 0);
        end
        clear_inputs();
        reset_n = 1'b1;
        tick();

        // R routing table (combinational, FSMs idle)
        for (int v = 0; v < 8; v++) begin
            bus.m_rid      = rv[v].rid;
            bus.m_resp.r   = '{valid:1'b1, data:rv[v].data, resp:2'd0, last:1'b0};
            for (int i = 0; i < 3; i++) bus.s_req[i].rready = rv[v].rready[i];
            #1;
            for (int i = 0; i < 3; i++)
                chk($sformatf("rtab%0d_rvalid%0d", v, i), bus.s_resp[i].r.valid, rv[v].exp_valid[i]);
            chk($sformatf("rtab%0d_m_rready", v), bus.m_req.rready, rv[v].exp_rready);
            if (rv[v].rid < 4'd3)
                chk($sformatf("rtab%0d_rdata", v), bus.s_resp[rv[v].rid].r.data, rv[v].data);
        end
        clear_inputs();
        tick();

        // Single icache AR followed by a 16-beat read burst
        bus.s_req[0].ar    = mk_ax(32'h1FC0_0000, 4'd15);
        bus.m_resp.arready = 1'b1;
        #1;
        chk("ar_first_cycle_valid", bus.m_req.ar.valid, 0);
        chk("ar_first_cycle_ready", bus.s_resp[0].arready, 0);
        tick();
        chk("ar_ic_valid",   bus.m_req.ar.valid, 1);
        chk("ar_ic_id",      bus.m_arid, 0);
        chk("ar_ic_addr",    bus.m_req.ar.addr, 32'h1FC0_0000);
        chk("ar_ic_len",     bus.m_req.ar.len, 15);
        chk("ar_ic_cache",   bus.m_req.ar.cache, 3);
        chk("ar_ic_arready", bus.s_resp[0].arready, 1);
        chk("ar_dc_arready", bus.s_resp[1].arready, 0);
        tick();
        bus.s_req[0].ar = '0;
        #1;
        chk("ar_after_hs_valid", bus.m_req.ar.valid, 0);
        for (int b = 0; b < 16; b++) begin
            bus.m_rid           = 4'd0;
            bus.m_resp.r        = '{valid:1'b1, data:32'hC000 + b, resp:2'd0, last:(b == 15)};
            bus.s_req[0].rready = 1'b1;
            #1;
            chk("rb_ic_valid", bus.s_resp[0].r.valid, 1);
            chk("rb_others",   bus.s_resp[1].r.valid | bus.s_resp[2].r.valid, 0);
            chk("rb_last",     bus.s_resp[0].r.last, (b == 15));
            chk("rb_data",     bus.s_resp[0].r.data, 32'hC000 + b);
            tick();
        end
        clear_inputs();

        // dcache and uncached AR together
        bus.m_resp.arready = 1'b1;
        bus.s_req[1].ar    = mk_ax(32'h0000_1000, 4'd0);
        bus.s_req[2].ar    = mk_ax(32'h0000_2000, 4'd0);
        tick();
        chk("rr_first_id",      bus.m_arid, 1);
        chk("rr_first_addr",    bus.m_req.ar.addr, 32'h1000);
        chk("rr_first_rdy_dc",  bus.s_resp[1].arready, 1);
        chk("rr_first_rdy_unc", bus.s_resp[2].arready, 0);
        tick();
        bus.s_req[1].ar.valid = 1'b0;
        #1;
        chk("rr_gap_valid", bus.m_req.ar.valid, 0);
        tick();
        chk("rr_second_id",   bus.m_arid, 2);
        chk("rr_second_addr", bus.m_req.ar.addr, 32'h2000);
        chk("rr_second_rdy",  bus.s_resp[2].arready, 1);
        tick();
        bus.s_req[2].ar.valid = 1'b0;

        // icache and dcache AR together
        bus.s_req[0].ar = mk_ax(32'h0000_0100, 4'd0);
        bus.s_req[1].ar = mk_ax(32'h0000_0200, 4'd0);
        tick();
`ifdef AXI_ARB_FIXED_PRIO_EN
        chk("prio_first_id", bus.m_arid, 1);
        tick();
        tick();
        chk("prio_repeat_id", bus.m_arid, 1);
        tick();
        bus.s_req[1].ar.valid = 1'b0;
        tick();
        chk("prio_ic_id",   bus.m_arid, 0);
        chk("prio_ic_addr", bus.m_req.ar.addr, 32'h100);
        tick();
        bus.s_req[0].ar.valid = 1'b0;
`else
        chk("ptr_wrap_id", bus.m_arid, 0);
        tick();
        bus.s_req[0].ar.valid = 1'b0;
        tick();
        chk("ptr_next_id",   bus.m_arid, 1);
        chk("ptr_next_addr", bus.m_req.ar.addr, 32'h200);
        tick();
        bus.s_req[1].ar.valid = 1'b0;
`endif
        clear_inputs();
        tick();

        // dcache write with late awready and a waiting uncached AW
        bus.s_req[1].aw   = mk_ax(32'h0000_3000, 4'd3);
        bus.s_req[1].w    = '{valid:1'b1, data:32'hD0, strb:4'hF, last:1'b0};
        bus.s_req[2].aw   = mk_ax(32'h0000_4000, 4'd3);
        bus.m_resp.wready = 1'b1;
        #1;
        chk("aw_first_cycle_valid", bus.m_req.aw.valid, 0);
        tick();
        chk("aw_dc_valid",   bus.m_req.aw.valid, 1);
        chk("aw_dc_id",      bus.m_awid, 1);
        chk("aw_dc_addr",    bus.m_req.aw.addr, 32'h3000);
        chk("aw_w_blocked",  bus.m_req.w.valid, 0);
        chk("aw_dc_wready",  bus.s_resp[1].wready, 0);
        chk("aw_dc_awready", bus.s_resp[1].awready, 0);
        repeat (4) begin
            tick();
            chk("aw_wait_w_blocked", bus.m_req.w.valid, 0);
        end
        bus.m_resp.awready = 1'b1;
        #1;
        chk("aw_dc_awready_hs",  bus.s_resp[1].awready, 1);
        chk("aw_unc_awready_hs", bus.s_resp[2].awready, 0);
        tick();
        bus.s_req[1].aw.valid = 1'b0;
        bus.m_resp.awready    = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.s_req[1].w = '{valid:1'b1, data:32'hD0 + b, strb:4'hF, last:(b == 3)};
            #1;
            chk("w_valid",      bus.m_req.w.valid, 1);
            chk("w_id",         bus.m_wid, 1);
            chk("w_data",       bus.m_req.w.data, 32'hD0 + b);
            chk("w_last",       bus.m_req.w.last, (b == 3));
            chk("w_dc_wready",  bus.s_resp[1].wready, 1);
            chk("w_unc_wready", bus.s_resp[2].wready, 0);
            chk("w_unc_aw_held", bus.m_req.aw.valid, 0);
            tick();
        end
        bus.s_req[1].w      = '0;
        bus.m_resp.b        = '{valid:1'b1, resp:2'd0};
        bus.m_bid           = 4'd1;
        bus.s_req[1].bready = 1'b1;
        #1;
        chk("b_dc_valid",  bus.s_resp[1].b.valid, 1);
        chk("b_dc_resp",   bus.s_resp[1].b.resp, 0);
        chk("b_unc_valid", bus.s_resp[2].b.valid, 0);
        chk("b_m_bready",  bus.m_req.bready, 1);
        chk("b_unc_aw",    bus.m_req.aw.valid, 0);
        tick();
        bus.m_resp.b        = '0;
        bus.s_req[1].bready = 1'b0;
        #1;
        chk("b_idle_aw", bus.m_req.aw.valid, 0);
        tick();
        chk("aw_unc_id",   bus.m_awid, 2);
        chk("aw_unc_addr", bus.m_req.aw.addr, 32'h4000);

        // Reset during beat 2 of the uncached W burst
        bus.m_resp.awready = 1'b1;
        #1;
        chk("aw_unc_awready", bus.s_resp[2].awready, 1);
        tick();
        bus.s_req[2].aw.valid = 1'b0;
        bus.m_resp.awready    = 1'b0;
        bus.s_req[2].w        = '{valid:1'b1, data:32'hE0, strb:4'hF, last:1'b0};
        #1;
        chk("rst_seq_beat1", bus.m_req.w.valid, 1);
        tick();
        bus.s_req[2].w.data = 32'hE1;
        #1;
        chk("rst_seq_beat2_data", bus.m_req.w.data, 32'hE1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_wvalid", bus.m_req.w.valid, 0);
        chk("rst_async_wdata",  bus.m_req.w.data, 0);
        chk("rst_async_wid",    bus.m_wid, 0);
        chk("rst_async_wready", bus.s_resp[2].wready, 0);
        chk("rst_async_aw",     bus.m_req.aw.valid, 0);
        clear_inputs();
        tick();
        tick();
        reset_n = 1'b1;
        bus.s_req[0].aw    = mk_ax(32'h0000_5000, 4'd0);
        bus.m_resp.awready = 1'b1;
        #1;
        chk("post_rst_aw_latency", bus.m_req.aw.valid, 0);
        tick();
        chk("post_rst_aw_valid", bus.m_req.aw.valid, 1);
        chk("post_rst_aw_id",    bus.m_awid, 0);
        chk("post_rst_aw_addr",  bus.m_req.aw.addr, 32'h5000);
        chk("post_rst_awready",  bus.s_resp[0].awready, 1);
        tick();
        clear_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
